// File: rtl/accel_spi_reader.sv
// accel_spi_reader
// SPI mode-3 master for a 3-axis accelerometer. After reset it writes one
// configuration register, then reads the X and Y high-byte registers every
// POLL_CYCLES pixel_clk cycles and publishes both bytes together with a
// one-cycle accel_valid strobe.
// Build option: define ACCEL_ID_CHECK_EN to read WHO_AM_I (0x0F, expecting
// 0x33) before configuring; without it id_error is held at 0.
module accel_spi_reader #(
    parameter int unsigned CLK_DIV     = 18,
    parameter logic [5:0]  INIT_ADDR   = 6'h20,
    parameter logic [7:0]  INIT_DATA   = 8'h57,
    parameter logic [5:0]  X_ADDR      = 6'h29,
    parameter logic [5:0]  Y_ADDR      = 6'h2B,
    parameter int unsigned POLL_CYCLES = 36000,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [7:0] accel_data_x,
    output logic [7:0] accel_data_y,
    output logic       accel_valid,
    output logic       busy,
    output logic       id_error
);

    // Half-period divider
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Tick steps inside one transaction: odd steps 1..31 drop SCLK and shift
    // MOSI, even steps 2..32 raise SCLK and sample MISO, step 33 raises CS_n,
    // and the transaction ends after CS_GAP further ticks.
    localparam int unsigned STEP_CS   = 33;
    localparam int unsigned STEP_DONE = 33 + CS_GAP;
    localparam int unsigned STEP_W    = $clog2(STEP_DONE + 1);
    localparam logic [STEP_W-1:0] STEP_CS_V   = STEP_W'(STEP_CS);
    localparam logic [STEP_W-1:0] STEP_DONE_V = STEP_W'(STEP_DONE);

    // Poll interval counter
    localparam int unsigned POLL_W = $clog2(POLL_CYCLES + 1);
    localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);

    // Command words: {R/W, no-increment, address, data byte}
    localparam logic [15:0] CMD_INIT = {1'b0, 1'b0, INIT_ADDR, INIT_DATA};
    localparam logic [15:0] CMD_RD_X = {1'b1, 1'b0, X_ADDR, 8'h00};
    localparam logic [15:0] CMD_RD_Y = {1'b1, 1'b0, Y_ADDR, 8'h00};
`ifdef ACCEL_ID_CHECK_EN
    localparam logic [15:0] CMD_RD_ID = {1'b1, 1'b0, 6'h0F, 8'h00};
    localparam logic [7:0]  ID_VALUE  = 8'h33;
`endif

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_INIT_WR = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RD_X    = 3'd3,
        ST_RD_Y    = 3'd4,
        ST_UPDATE  = 3'd5,
        ST_RD_ID   = 3'd6,
        ST_ID_WAIT = 3'd7
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [STEP_W-1:0]   r_step;
    logic [15:0]         r_tx;
    logic [7:0]          r_rx;
    logic [7:0]          r_stage_x;
    logic [POLL_W-1:0]   r_poll;
    logic                r_miso_s1;
    logic                r_miso_s2;
    logic                w_in_xfer;
    logic                w_tick;
    logic [STEP_W-1:0]   w_step_next;

    // Flag the states in which an SPI transaction (including its CS gap) runs
    always_comb begin
        w_in_xfer = 1'b0;
        case (r_state)
            ST_INIT_WR, ST_RD_X, ST_RD_Y, ST_RD_ID: w_in_xfer = 1'b1;
            default:                                 w_in_xfer = 1'b0;
        endcase
    end

    assign w_tick      = w_in_xfer && (r_div == DIV_LAST);
    assign w_step_next = r_step + STEP_W'(1);

    // Half-period tick divider; held at zero outside transactions so the first
    // tick always lands CLK_DIV cycles after CS_n falls
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!w_in_xfer) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the slave data line
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_miso_s1 <= spi_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    // Control FSM: sequences transactions, drives SPI pins and commits results
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_START;
            r_step       <= '0;
            r_tx         <= 16'h0000;
            r_rx         <= 8'h00;
            r_stage_x    <= 8'h00;
            r_poll       <= '0;
            spi_sclk     <= 1'b1;
            spi_cs_n     <= 1'b1;
            spi_mosi     <= 1'b0;
            accel_data_x <= 8'h00;
            accel_data_y <= 8'h00;
            accel_valid  <= 1'b0;
            busy         <= 1'b0;
            id_error     <= 1'b0;
        end else begin
            accel_valid <= 1'b0;
            if (r_poll != '0) begin
                r_poll <= r_poll - POLL_W'(1);
            end

            case (r_state)
                ST_START: begin
                    spi_cs_n <= 1'b0;
                    busy     <= 1'b1;
                    r_step   <= '0;
`ifdef ACCEL_ID_CHECK_EN
                    r_tx     <= CMD_RD_ID;
                    r_state  <= ST_RD_ID;
`else
                    r_tx     <= CMD_INIT;
                    r_state  <= ST_INIT_WR;
`endif
                end

                ST_WAIT: begin
                    if (r_poll == '0) begin
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        r_step   <= '0;
                        r_tx     <= CMD_RD_X;
                        r_poll   <= POLL_LOAD;
                        r_state  <= ST_RD_X;
                    end else begin
                        r_state  <= ST_WAIT;
                    end
                end

                ST_UPDATE: begin
                    r_state <= ST_WAIT;
                end

                ST_INIT_WR, ST_RD_X, ST_RD_Y, ST_RD_ID: begin
                    if (!w_tick) begin
                        r_step <= r_step;
                    end else if (w_step_next == STEP_DONE_V) begin
                        // End of transaction (CS gap elapsed); the next
                        // transaction, if any, pulls CS_n low again below.
                        r_step   <= '0;
                        spi_cs_n <= 1'b1;
                        spi_sclk <= 1'b1;
                        spi_mosi <= 1'b0;
                        case (r_state)
                            ST_INIT_WR: begin
                                busy    <= 1'b0;
                                r_state <= ST_WAIT;
                            end
                            ST_RD_X: begin
                                // X is staged so the outputs only move once Y is in hand
                                r_stage_x <= r_rx;
                                spi_cs_n  <= 1'b0;
                                r_tx      <= CMD_RD_Y;
                                r_state   <= ST_RD_Y;
                            end
                            ST_RD_Y: begin
                                accel_data_x <= r_stage_x;
                                accel_data_y <= r_rx;
                                accel_valid  <= 1'b1;
                                busy         <= 1'b0;
                                r_state      <= ST_UPDATE;
                            end
`ifdef ACCEL_ID_CHECK_EN
                            ST_RD_ID: begin
                                if (r_rx == ID_VALUE) begin
                                    id_error <= 1'b0;
                                    spi_cs_n <= 1'b0;
                                    r_tx     <= CMD_INIT;
                                    r_state  <= ST_INIT_WR;
                                end else begin
                                    id_error <= 1'b1;
                                    r_poll   <= POLL_LOAD;
                                    r_state  <= ST_ID_WAIT;
                                end
                            end
`endif
                            default: begin
                                busy    <= 1'b0;
                                r_state <= ST_START;
                            end
                        endcase
                    end else if (w_step_next >= STEP_CS_V) begin
                        // Last edge done: release CS_n and hold SCLK high through the gap
                        r_step   <= w_step_next;
                        spi_cs_n <= 1'b1;
                        spi_sclk <= 1'b1;
                        spi_mosi <= 1'b0;
                    end else if (w_step_next[0]) begin
                        // Falling SCLK: present the next command/data bit, MSB first
                        r_step   <= w_step_next;
                        spi_sclk <= 1'b0;
                        spi_mosi <= r_tx[15];
                        r_tx     <= {r_tx[14:0], 1'b0};
                    end else begin
                        // Rising SCLK: capture the synchronized slave bit
                        r_step   <= w_step_next;
                        spi_sclk <= 1'b1;
                        r_rx     <= {r_rx[6:0], r_miso_s2};
                    end
                end

`ifdef ACCEL_ID_CHECK_EN
                ST_ID_WAIT: begin
                    if (r_poll == '0) begin
                        spi_cs_n <= 1'b0;
                        r_step   <= '0;
                        r_tx     <= CMD_RD_ID;
                        r_state  <= ST_RD_ID;
                    end else begin
                        r_state  <= ST_ID_WAIT;
                    end
                end
`endif

                default: begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b1;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader
// Randomized bench: an SPI slave model serves X/Y bytes from $urandom and
// queues the expected published pair; a monitor checks each accel_valid
// pulse, poll spacing, SPI framing, busy and the reset/abort behaviour.
// Build option ACCEL_ID_CHECK_EN enables the WHO_AM_I retry scenario.
`timescale 1ns/1ps
module tb_accel_spi_reader;

    localparam int POLL        = 5000;
    localparam int SCLK_PERIOD = 36;
`ifdef ACCEL_ID_CHECK_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    logic       pixel_clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0] accel_data_x, accel_data_y;
    logic       accel_valid, busy, id_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    accel_spi_reader #(.POLL_CYCLES(POLL)) dut (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .accel_data_x (accel_data_x),
        .accel_data_y (accel_data_y),
        .accel_valid  (accel_valid),
        .busy         (busy),
        .id_error     (id_error)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cs_n"},  spi_cs_n,     32'd1);
        check({tag, "_sclk"},  spi_sclk,     32'd1);
        check({tag, "_mosi"},  spi_mosi,     32'd0);
        check({tag, "_x"},     accel_data_x, 32'd0);
        check({tag, "_y"},     accel_data_y, 32'd0);
        check({tag, "_valid"}, accel_valid,  32'd0);
        check({tag, "_busy"},  busy,         32'd0);
        check({tag, "_id"},    id_error,     32'd0);
    endtask

    // ---------------- reference model / scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] m_exp_w;
    logic [15:0] m_e;
    logic        init_seen = 1'b0;
    logic        id_ok     = 1'b0;
    int          rd_idx    = 0;
    int          id_reads  = 0;
    int          nvalid    = 0;
    int          last_valid_cyc = -1;
    logic [7:0]  last_x    = 8'h00;

    // ---------------- SPI slave model ----------------
    logic [15:0] s_word = 16'h0000;
    int          s_rise = 0;
    int          s_fall = 0;
    logic [7:0]  s_resp = 8'h00;
    logic [7:0]  s_x_pend = 8'h00;
    logic        s_is_y = 1'b0;
    logic        s_id_ok = 1'b0;
    logic        use_fixed = 1'b1;
    logic [7:0]  id_val = 8'h33;
    int          last_rise_cyc = 0;

    always @(negedge spi_cs_n) begin
        s_rise  = 0;
        s_fall  = 0;
        s_word  = 16'h0000;
        s_is_y  = 1'b0;
        s_id_ok = 1'b0;
        spi_miso = 1'b0;
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n) begin
            s_fall++;
            spi_miso = (s_fall >= 9) ? s_resp[3'(16 - s_fall)] : 1'b0;
        end
    end

    always @(posedge spi_sclk) begin
        if (!spi_cs_n && rst_n) begin
            s_word = {s_word[14:0], spi_mosi};
            s_rise++;
            if (s_rise >= 2) check("sclk_period", cyc - last_rise_cyc, SCLK_PERIOD);
            last_rise_cyc = cyc;
            if (s_rise == 8) begin
                s_resp = 8'h00;
                if (s_word[7]) begin
                    case (s_word[5:0])
                        6'h29: begin
                            s_resp   = use_fixed ? 8'h12 : 8'($urandom);
                            s_x_pend = s_resp;
                        end
                        6'h2B: begin
                            s_resp    = use_fixed ? 8'hF0 : 8'($urandom);
                            s_is_y    = 1'b1;
                            use_fixed = 1'b0;
                        end
                        6'h0F: begin
                            s_resp  = id_val;
                            s_id_ok = (id_val == 8'h33);
                        end
                        default: s_resp = 8'h00;
                    endcase
                end
            end
            if (s_rise == 16 && s_is_y) exp_q.push_back({s_x_pend, s_resp});
        end
    end

    // Transaction monitor: each CS_n-high edge closes one 16-bit frame
    always @(posedge spi_cs_n) begin
        if (rst_n) begin
            check("sclk_rises", s_rise, 32'd16);
            if (!init_seen) m_exp_w = (ID_EN && !id_ok) ? 16'h8F00 : 16'h2057;
            else            m_exp_w = rd_idx[0] ? 16'hAB00 : 16'hA900;
            check("mosi_word", s_word, m_exp_w);
            if (m_exp_w == 16'h2057) init_seen = 1'b1;
            else if (m_exp_w == 16'h8F00) begin
                id_reads++;
                if (s_id_ok) id_ok = 1'b1;
            end else rd_idx++;
        end
    end

    // Output monitor: pops the scoreboard on each valid pulse
    logic prev_valid = 1'b0;
    logic prev_cs = 1'b1;
    logic [7:0] prev_x = 8'h00, prev_y = 8'h00;

    always @(negedge pixel_clk) begin
        if (rst_n) begin
            if (accel_valid) begin
                check("pending_updates", exp_q.size(), 32'd1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check("data_x", accel_data_x, m_e[15:8]);
                    check("data_y", accel_data_y, m_e[7:0]);
                    last_x = m_e[15:8];
                end
                if (last_valid_cyc >= 0) check("poll_spacing", cyc - last_valid_cyc, POLL);
                last_valid_cyc = cyc;
                nvalid++;
            end
            if (prev_valid) check("valid_one_cycle", accel_valid, 32'd0);
            if (accel_data_x != prev_x || accel_data_y != prev_y)
                check("atomic_update", accel_valid, 32'd1);
            if (prev_cs && !spi_cs_n) check("busy_in_xfer", busy, 32'd1);
            if (last_valid_cyc >= 0 && cyc == last_valid_cyc + 100) begin
                check("busy_idle", busy, 32'd0);
                check("cs_idle", spi_cs_n, 32'd1);
            end
        end
        prev_valid = accel_valid;
        prev_cs    = spi_cs_n;
        prev_x     = accel_data_x;
        prev_y     = accel_data_y;
    end

    // Stimulus
    initial begin
        int base;
        rst_n    = 1'b0;
        spi_miso = 1'b0;
        id_val   = ID_EN ? 8'h32 : 8'h33;
        repeat (5) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_reset("rst_hold");
        rst_n = 1'b1;

`ifdef ACCEL_ID_CHECK_EN
        for (int i = 0; i < 20000 && id_reads < 2; i++) @(posedge pixel_clk);
        check("id_retries_seen", (id_reads >= 2), 32'd1);
        repeat (100) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check("id_error_set", id_error, 32'd1);
        check("no_valid_in_id_loop", nvalid, 32'd0);
        id_val = 8'h33;
        for (int i = 0; i < 20000 && !init_seen; i++) @(posedge pixel_clk);
        check("init_after_id", init_seen, 32'd1);
        @(negedge pixel_clk);
        check("id_error_clear", id_error, 32'd0);
`endif

        for (int i = 0; i < 30000 && nvalid < 4; i++) @(posedge pixel_clk);
        check("reached_4_updates", (nvalid >= 4), 32'd1);

        // Abort during the 9th SCLK of the Y read
        for (int i = 0; i < 8000 && !(s_is_y && s_fall == 9); i++) @(posedge pixel_clk);
        check("reached_rd_y_sclk9", (s_is_y && s_fall == 9), 32'd1);
        check("x_held_during_rd_y", accel_data_x, last_x);
        @(posedge pixel_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_abort");
        exp_q.delete();
        init_seen      = 1'b0;
        id_ok          = 1'b0;
        rd_idx         = 0;
        last_valid_cyc = -1;
        base           = nvalid;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_reset("abort_hold");
        rst_n = 1'b1;

        for (int i = 0; i < 15000 && nvalid < base + 2; i++) @(posedge pixel_clk);
        check("updates_after_abort", (nvalid >= base + 2), 32'd1);
        check("init_after_abort", init_seen, 32'd1);
        check("id_error_final", id_error, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
